// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and Data_Memory signal bundle for the two-port memory arbiter
interface data_mem_arbiter_if;
    logic       req0;
    logic       req1;
    logic       rd_wr0;
    logic       rd_wr1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata;
    logic       mem_rd_wr;
    logic [7:0] mem_address;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_bus;

    modport slave (
        input  req0, req1, rd_wr0, rd_wr1, addr0, addr1, wdata0, wdata1, mem_data_bus,
        output gnt0, gnt1, done0, done1, rdata, mem_rd_wr, mem_address, mem_data_in
    );

    modport master (
        output req0, req1, rd_wr0, rd_wr1, addr0, addr1, wdata0, wdata1, mem_data_bus,
        input  gnt0, gnt1, done0, done1, rdata, mem_rd_wr, mem_address, mem_data_in
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter sharing one Data_Memory port between two requesters
module data_mem_arbiter #(
    parameter int READ_WAIT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    data_mem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

    state_t     r_state;
    logic       r_last;
    logic       r_sel;
    logic [2:0] r_wait_cnt;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_done0;
    logic       r_done1;
    logic       r_mem_rd_wr;
    logic [7:0] r_mem_address;
    logic [7:0] r_mem_data_in;
    logic [7:0] r_rdata;

    logic       w_any_req;
    logic       w_win;

    assign w_any_req = bus.req0 | bus.req1;
    // On a tie the requester that was not served last wins
    assign w_win     = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_sel         <= 1'b0;
            r_wait_cnt    <= 3'd0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_mem_rd_wr   <= 1'b1;
            r_mem_address <= 8'h00;
            r_mem_data_in <= 8'h00;
            r_rdata       <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel         <= w_win;
                        r_last        <= w_win;
                        r_gnt0        <= ~w_win;
                        r_gnt1        <= w_win;
                        r_mem_rd_wr   <= w_win ? bus.rd_wr1 : bus.rd_wr0;
                        r_mem_address <= w_win ? bus.addr1  : bus.addr0;
                        r_mem_data_in <= w_win ? bus.wdata1 : bus.wdata0;
                        r_state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_mem_rd_wr <= 1'b1;
                    // r_mem_rd_wr low here means the captured command is a write
                    if (!r_mem_rd_wr) begin
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                        r_state <= S_DONE;
                    end else if (READ_WAIT == 0) begin
                        r_rdata <= bus.mem_data_bus;
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= 3'd0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_rdata <= bus.mem_data_bus;
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt0        = r_gnt0;
    assign bus.gnt1        = r_gnt1;
    assign bus.done0       = r_done0;
    assign bus.done1       = r_done1;
    assign bus.rdata       = r_rdata;
    assign bus.mem_rd_wr   = r_mem_rd_wr;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data_in = r_mem_data_in;
endmodule
